// File: rtl/pf_unpack_pkg.sv
// Shared constants, helpers and state encoding for the FIFO read-side unpacker.
package pf_unpack_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int unsigned cwidth(input int unsigned n);
    return (clog2(n) == 0) ? 1 : clog2(n);
  endfunction

  function automatic int unsigned lanes(input int unsigned in_w, input int unsigned out_w);
    return in_w / out_w;
  endfunction

  function automatic bit cfg_ok(input int unsigned in_w, input int unsigned out_w,
                                input int unsigned line_beats);
    return (out_w != 0) && (in_w % out_w == 0) && (line_beats % lanes(in_w, out_w) == 0);
  endfunction

endpackage

// File: rtl/pf_lane_sel.sv
// Holding register for one popped FIFO word, lane index and lane mux; decides pops and beat accepts.
module pf_lane_sel
  import pf_unpack_pkg::*;
#(
  parameter int unsigned IN_W      = 256,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             active,
  input  logic             pop_ok,
  input  logic [IN_W-1:0]  fifo_rd_data,
  input  logic             fifo_rd_vld,
  input  logic             m_ready,
  output logic             pop_c,
  output logic             accept_c,
  output logic             hv,
  output logic [OUT_W-1:0] data_c
);

  localparam int unsigned R    = lanes(IN_W, OUT_W);
  localparam int unsigned LN_W = cwidth(R);
  localparam logic [LN_W-1:0] LN_LAST = LN_W'(R - 1);

  logic [IN_W-1:0] hold_q, hold_d;
  logic            hv_q, hv_d;
  logic [LN_W-1:0] ln_q, ln_d;
  logic [LN_W-1:0] sel;
  logic            last_lane;

  // A pop may land on the same edge as the last-lane accept, giving gapless words.
  always_comb begin
    hold_d    = hold_q;
    hv_d      = hv_q;
    ln_d      = ln_q;
    last_lane = (ln_q == LN_LAST);
    accept_c  = active & hv_q & m_ready;
    pop_c     = active & fifo_rd_vld & pop_ok & (~hv_q | (m_ready & last_lane));
    if (!active) begin
      hv_d = 1'b0;
      ln_d = '0;
    end else if (pop_c) begin
      hold_d = fifo_rd_data;
      hv_d   = 1'b1;
      ln_d   = '0;
    end else if (accept_c) begin
      if (last_lane) begin
        hv_d = 1'b0;
        ln_d = '0;
      end else begin
        ln_d = ln_q + LN_W'(1);
      end
    end
    sel    = (LSB_FIRST != 0) ? ln_q : (LN_LAST - ln_q);
    data_c = '0;
    for (int unsigned i = 0; i < R; i++) begin
      if (sel == LN_W'(i)) data_c = hold_q[i*OUT_W +: OUT_W];
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      hold_q <= '0;
      hv_q   <= 1'b0;
      ln_q   <= '0;
    end else begin
      hold_q <= hold_d;
      hv_q   <= hv_d;
      ln_q   <= ln_d;
    end
  end

  assign hv = hv_q;

endmodule

// File: rtl/pf_fifo_rd_unpack.sv
// Pops wide words from a show-ahead FIFO and emits them as framed OUT_W-bit beats with SOF/EOL.
module pf_fifo_rd_unpack
  import pf_unpack_pkg::*;
#(
  parameter int unsigned IN_W       = 256,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned LINE_BEATS = 1280,
  parameter int unsigned LINES      = 720,
  parameter int unsigned LSB_FIRST  = 1
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             frame_start,
  input  logic [IN_W-1:0]  fifo_rd_data,
  input  logic             fifo_rd_vld,
  output logic             fifo_rd_en,
  output logic [OUT_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_sof,
  output logic             m_eol,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      stall_cnt
);

  localparam int unsigned R      = lanes(IN_W, OUT_W);
  localparam int unsigned WORDS  = (LINES * LINE_BEATS) / R;
  localparam int unsigned PIX_W  = cwidth(LINE_BEATS);
  localparam int unsigned LINE_W = cwidth(LINES);
  localparam int unsigned WRD_W  = cwidth(WORDS + 1);
  localparam int unsigned STL_W  = 16;
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(LINE_BEATS - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES - 1);

  if (!cfg_ok(IN_W, OUT_W, LINE_BEATS)) begin : g_bad_cfg
    $error("pf_fifo_rd_unpack: IN_W must be a multiple of OUT_W and LINE_BEATS a multiple of IN_W/OUT_W");
  end

  state_e            state_q, state_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [WRD_W-1:0]  word_q, word_d;
  logic [STL_W-1:0]  stall_q, stall_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              active, pop, accept, hv, last_word_taken, frame_end;
  logic [OUT_W-1:0]  lane_data;

  assign active          = (state_q == ACTIVE);
  assign last_word_taken = (word_q == WRD_W'(WORDS));

  pf_lane_sel #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_lane_sel (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .active       (active),
    .pop_ok       (~last_word_taken),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_vld  (fifo_rd_vld),
    .m_ready      (m_ready),
    .pop_c        (pop),
    .accept_c     (accept),
    .hv           (hv),
    .data_c       (lane_data)
  );

  // Stall counts only true starvation: downstream ready, nothing held, nothing arriving.
  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    line_d    = line_q;
    word_d    = word_q;
    stall_d   = stall_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    frame_end = accept & (pix_q == PIX_LAST) & (line_q == LINE_LAST);
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = ACTIVE;
          pix_d   = '0;
          line_d  = '0;
          word_d  = '0;
          stall_d = '0;
          busy_d  = 1'b1;
        end
      end
      ACTIVE: begin
        if (pop) word_d = word_q + WRD_W'(1);
        if (accept) begin
          if (pix_q == PIX_LAST) begin
            pix_d  = '0;
            line_d = (line_q == LINE_LAST) ? '0 : (line_q + LINE_W'(1));
          end else begin
            pix_d = pix_q + PIX_W'(1);
          end
        end
        if (m_ready && !hv && !pop && (stall_q != {STL_W{1'b1}})) stall_d = stall_q + STL_W'(1);
        if (frame_end) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q <= IDLE;
      pix_q   <= '0;
      line_q  <= '0;
      word_q  <= '0;
      stall_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      word_q  <= word_d;
      stall_q <= stall_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign fifo_rd_en = pop;
  assign m_valid    = hv;
  assign m_data     = lane_data;
  assign m_sof      = hv & (pix_q == '0) & (line_q == '0);
  assign m_eol      = hv & (pix_q == PIX_LAST);
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_pf_fifo_rd_unpack.sv
// Scoreboard bench: FIFO model feeds two unpackers (LSB-first and MSB-first); a monitor checks beats and framing.
module tb_pf_fifo_rd_unpack;

  localparam int unsigned IN_W  = 64;
  localparam int unsigned OUT_W = 16;
  localparam int unsigned R     = IN_W / OUT_W;
  localparam int unsigned LB    = 8;
  localparam int unsigned NL    = 2;
  localparam int unsigned FB    = LB * NL;
  localparam int unsigned WORDS = FB / R;

  logic             rd_clk = 1'b0;
  logic             rd_rst;
  logic             frame_start;
  logic [IN_W-1:0]  fifo_rd_data;
  logic             fifo_rd_vld;
  logic             m_ready;

  logic             a_rd_en, a_valid, a_sof, a_eol, a_busy, a_done;
  logic [OUT_W-1:0] a_data;
  logic [15:0]      a_stall;
  logic             b_rd_en, b_valid, b_sof, b_eol, b_busy, b_done;
  logic [OUT_W-1:0] b_data;
  logic [15:0]      b_stall;

  pf_fifo_rd_unpack #(.IN_W(IN_W), .OUT_W(OUT_W), .LINE_BEATS(LB), .LINES(NL), .LSB_FIRST(1)) u_dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .frame_start(frame_start),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_en(a_rd_en),
    .m_data(a_data), .m_valid(a_valid), .m_ready(m_ready), .m_sof(a_sof), .m_eol(a_eol),
    .busy(a_busy), .frame_done(a_done), .stall_cnt(a_stall)
  );

  pf_fifo_rd_unpack #(.IN_W(IN_W), .OUT_W(OUT_W), .LINE_BEATS(LB), .LINES(NL), .LSB_FIRST(0)) u_dut_msb (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .frame_start(frame_start),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_en(b_rd_en),
    .m_data(b_data), .m_valid(b_valid), .m_ready(m_ready), .m_sof(b_sof), .m_eol(b_eol),
    .busy(b_busy), .frame_done(b_done), .stall_cnt(b_stall)
  );

  always #5 rd_clk = ~rd_clk;

  int checks = 0;
  int errors = 0;

  // Stimulus-side state
  logic [IN_W-1:0] fq[$];
  int  pops_applied = 0;
  int  cyc_n        = 0;
  int  ready_mode   = 0;
  bit  vld_hold     = 1'b0;
  bit  chk_nobubble = 1'b0;
  int  stall_target = 0;

  // Monitor-side state
  logic [OUT_W-1:0] exp_a[$];
  logic [OUT_W-1:0] exp_b[$];
  int  idx         = 0;
  int  frame_pops  = 0;
  int  pops_seen   = 0;
  int  frames_done = 0;
  bit  tb_active   = 1'b0;
  bit  done_exp    = 1'b0;
  bit  hold_pend_a = 1'b0;
  bit  hold_pend_b = 1'b0;
  logic [OUT_W-1:0] prev_a, prev_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  always @(negedge rd_clk) begin : monitor
    logic [OUT_W-1:0] e;
    bit act_now;
    if (rd_rst) begin
      check("reset_outputs_a", 64'({a_valid, a_sof, a_eol, a_rd_en, a_busy, a_done, a_data, a_stall}), 64'd0);
      check("reset_outputs_b", 64'({b_valid, b_sof, b_eol, b_rd_en, b_busy, b_done, b_data, b_stall}), 64'd0);
      exp_a.delete();
      exp_b.delete();
      idx = 0; frame_pops = 0; tb_active = 1'b0; done_exp = 1'b0;
      hold_pend_a = 1'b0; hold_pend_b = 1'b0;
    end else begin
      act_now = tb_active;
      if (done_exp || a_done) begin
        check("frame_done", 64'(a_done), 64'(done_exp));
        if (done_exp) begin
          check("stall_cnt", 64'(a_stall), 64'(stall_target));
          frames_done++;
        end
      end
      done_exp = 1'b0;
      check("busy", 64'(a_busy), 64'(act_now));

      if (hold_pend_a) begin
        check("hold_valid_a", 64'(a_valid), 64'd1);
        check("hold_data_a", 64'(a_data), 64'(prev_a));
      end
      if (hold_pend_b) begin
        check("hold_valid_b", 64'(b_valid), 64'd1);
        check("hold_data_b", 64'(b_data), 64'(prev_b));
      end
      hold_pend_a = a_valid && !m_ready; prev_a = a_data;
      hold_pend_b = b_valid && !m_ready; prev_b = b_data;

      if (chk_nobubble && act_now && idx > 0) check("no_bubble", 64'(a_valid), 64'd1);

      if (a_valid && m_ready) begin
        if (exp_a.size() == 0) check("unexpected_beat_a", 64'(a_data), 64'hDEAD_0000);
        else begin
          e = exp_a.pop_front();
          check("beat_a", 64'(a_data), 64'(e));
          check("sof", 64'(a_sof), 64'(idx == 0));
          check("eol", 64'(a_eol), 64'((idx % LB) == LB - 1));
          idx++;
          if (idx == FB) begin
            check("pops_per_frame", 64'(frame_pops), 64'(WORDS));
            idx = 0; frame_pops = 0; done_exp = 1'b1; tb_active = 1'b0;
          end
        end
      end
      if (b_valid && m_ready) begin
        if (exp_b.size() == 0) check("unexpected_beat_b", 64'(b_data), 64'hDEAD_0000);
        else begin
          e = exp_b.pop_front();
          check("beat_b_msb_first", 64'(b_data), 64'(e));
        end
      end

      if (a_rd_en) begin
        check("pop_needs_vld_a", 64'(fifo_rd_vld), 64'd1);
        check("pop_legal_a", 64'(exp_a.size() == 0 && act_now), 64'd1);
        if (fifo_rd_vld) begin
          for (int i = 0; i < int'(R); i++) exp_a.push_back(fifo_rd_data[i*OUT_W +: OUT_W]);
          pops_seen++;
          frame_pops++;
        end
      end
      if (b_rd_en) begin
        check("pop_legal_b", 64'(exp_b.size() == 0 && fifo_rd_vld), 64'd1);
        if (fifo_rd_vld)
          for (int i = int'(R) - 1; i >= 0; i--) exp_b.push_back(fifo_rd_data[i*OUT_W +: OUT_W]);
      end

      if (frame_start && !act_now) tb_active = 1'b1;
    end
  end

  task automatic drive_fifo();
    fifo_rd_vld  = (fq.size() != 0) && !vld_hold;
    fifo_rd_data = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic cyc();
    @(posedge rd_clk);
    #1;
    while (pops_applied < pops_seen) begin
      void'(fq.pop_front());
      pops_applied++;
    end
    cyc_n++;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ((cyc_n % 4) == 0) || ((cyc_n % 4) == 3);
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    drive_fifo();
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_done < target) begin
      cyc();
      n++;
      if (n > budget) begin
        $display("FAIL frame_timeout: got %0d frames, expected %0d", frames_done, target);
        $fatal(1, "frame wait budget exhausted");
      end
    end
  endtask

  task automatic wait_idx(input int target, input int budget);
    int n;
    n = 0;
    while (idx != target) begin
      cyc();
      n++;
      if (n > budget) begin
        $display("FAIL beat_timeout: got beat index %0d, expected %0d", idx, target);
        $fatal(1, "beat wait budget exhausted");
      end
    end
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) fq.push_back({$urandom, $urandom});
    drive_fifo();
  endtask

  initial begin
    rd_rst = 1'b1; frame_start = 1'b0; m_ready = 1'b0;
    drive_fifo();
    repeat (3) cyc();
    rd_rst = 1'b0;
    repeat (2) cyc();

    // Known ramp data, always ready: 16 gapless beats 0x0001..0x0010.
    for (int k = 0; k < 4; k++) fq.push_back(64'h0004_0003_0002_0001 + 64'(k) * 64'h0004_0004_0004_0004);
    drive_fifo();
    chk_nobubble = 1'b1;
    start_frame();
    wait_frames(1, 100);

    // Ready pattern 1,0,0,1 with random data.
    ready_mode = 1;
    push_rand(4);
    start_frame();
    wait_frames(2, 200);

    // Random ready.
    ready_mode = 2;
    push_rand(4);
    start_frame();
    wait_frames(3, 200);

    // FIFO runs dry at a word boundary: five starved cycles.
    chk_nobubble = 1'b0;
    ready_mode = 0;
    stall_target = 5;
    push_rand(4);
    start_frame();
    wait_idx(7, 100);
    vld_hold = 1'b1;
    drive_fifo();
    repeat (6) cyc();
    vld_hold = 1'b0;
    drive_fifo();
    wait_frames(4, 100);
    stall_target = 0;

    // Reset mid-frame, restart, and a frame_start while busy is ignored.
    ready_mode = 2;
    push_rand(8);
    start_frame();
    ready_mode = 0;
    wait_idx(6, 100);
    rd_rst = 1'b1;
    repeat (2) cyc();
    rd_rst = 1'b0;
    cyc();
    ready_mode = 2;
    start_frame();
    wait_idx(3, 100);
    start_frame();
    wait_frames(5, 200);
    repeat (12) cyc();

    // Eight queued words: two back-to-back frames take four each.
    ready_mode = 0;
    while (fq.size() < 8) fq.push_back({$urandom, $urandom});
    drive_fifo();
    start_frame();
    wait_frames(6, 100);
    start_frame();
    wait_frames(7, 100);
    repeat (10) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
